acc_sequencer: RTL and testbench

ACC_SEQUENCER -- requirements
Module: acc_sequencer

---
 rtl/acc_sequencer.sv | 65 ++++++
 tb/tb_acc_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// acc_sequencer: decodes accumulator instructions into per-cycle shift/load/clear/set controls.
module acc_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         instr_valid,
  input  logic [7:0]   instr,
  input  logic [N-1:0] acc_value,
  output logic         instr_ready,
  output logic         busy,
  output logic         done,
  output logic         acc_clr_n,
  output logic         acc_set_n,
  output logic [1:0]   acc_ctrl,
  output logic [2:0]   acc_num_shift,
  output logic         acc_ls,
  output logic         acc_rs
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2;
  localparam logic [2:0] OP_NOP = 3'd0, OP_CLR = 3'd1, OP_SET = 3'd2, OP_LOAD = 3'd3,
                         OP_SHL = 3'd4, OP_SHR = 3'd5, OP_ASR = 3'd6, OP_ROT = 3'd7;
  logic [1:0] state;
  logic [2:0] op, amt, cnt;
  logic       dir, zero_work, exec, rot, unused_bits;
  assign unused_bits = ^{instr[1], acc_value};
  assign zero_work = instr[7:5] == OP_NOP || (instr[7:5] >= OP_SHL && instr[4:2] == 3'd0);
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      op    <= 3'd0;
      amt   <= 3'd0;
      cnt   <= 3'd0;
      dir   <= 1'b0;
    end else if (state == IDLE && instr_valid) begin
      op    <= instr[7:5];
      amt   <= instr[4:2];
      cnt   <= instr[4:2];
      dir   <= instr[0];
      state <= zero_work ? DONE : EXEC;
    end else if (state == EXEC) begin
      cnt   <= cnt - 3'd1;
      state <= (op != OP_ROT || cnt == 3'd1) ? DONE : EXEC;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
  assign exec = state == EXEC;
  assign rot  = op == OP_ROT;
  always_comb begin
    instr_ready   = state == IDLE;
    busy          = state == EXEC || state == DONE;
    done          = state == DONE;
    acc_clr_n     = !(exec && op == OP_CLR);
    acc_set_n     = !(exec && op == OP_SET);
    acc_ctrl      = !exec ? 2'b00 :
                    op == OP_LOAD ? 2'b01 :
                    (op == OP_SHL || (rot && !dir)) ? 2'b10 :
                    (op == OP_SHR || op == OP_ASR || rot) ? 2'b11 : 2'b00;
    acc_num_shift = !exec ? 3'd0 : rot ? 3'd1 : op >= OP_SHL ? amt : 3'd0;
    // Fill bits track the live accumulator so each rotate step sees the previous step's result.
    acc_ls        = exec && rot && !dir && acc_value[N-1];
    acc_rs        = exec && ((op == OP_ASR && acc_value[N-1]) || (rot && dir && acc_value[0]));
  end
endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: random and directed checks of acc_sequencer driving a behavioural accumulator.
module tb_acc_sequencer;
  logic       clk = 1'b0, clr = 1'b1, instr_valid = 1'b0, model_on = 1'b0;
  logic [7:0] instr = 8'h00, acc = 8'h00, load_data = 8'h00, lmask, rmask;
  logic       instr_ready, busy, done, acc_clr_n, acc_set_n, acc_ls, acc_rs;
  logic [1:0] acc_ctrl;
  logic [2:0] acc_num_shift;
  logic [1:0] c_ctrl;
  logic [2:0] c_ns;
  logic       c_rs, c_setn, c_clrn;
  int total = 0, bad = 0;

  acc_sequencer #(.N(8)) dut (
    .clk(clk), .clr(clr), .instr_valid(instr_valid), .instr(instr), .acc_value(acc),
    .instr_ready(instr_ready), .busy(busy), .done(done), .acc_clr_n(acc_clr_n),
    .acc_set_n(acc_set_n), .acc_ctrl(acc_ctrl), .acc_num_shift(acc_num_shift),
    .acc_ls(acc_ls), .acc_rs(acc_rs)
  );

  always #5 clk = ~clk;

  assign lmask = 8'((9'd1 << acc_num_shift) - 9'd1);
  assign rmask = ~(8'hFF >> acc_num_shift);
  always @(posedge clk)
    if (model_on)
      acc <= !acc_clr_n ? 8'h00 : !acc_set_n ? 8'hFF :
             acc_ctrl == 2'b01 ? load_data :
             acc_ctrl == 2'b10 ? ((acc << acc_num_shift) | (acc_ls ? lmask : 8'h00)) :
             acc_ctrl == 2'b11 ? ((acc >> acc_num_shift) | (acc_rs ? rmask : 8'h00)) : acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] a, input int k);
    return k == 0 ? a : 8'((a << k) | (a >> (8 - k)));
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] a, input int k);
    return k == 0 ? a : 8'((a >> k) | (a << (8 - k)));
  endfunction

  function automatic logic [7:0] ref_op(input int op, input int amt, input bit dir,
                                        input logic [7:0] a, input logic [7:0] ld);
    case (op)
      1: return 8'h00;
      2: return 8'hFF;
      3: return ld;
      4: return 8'(a << amt);
      5: return a >> amt;
      6: return 8'($signed(a) >>> amt);
      7: return dir ? rotr(a, amt) : rotl(a, amt);
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(input int op, input int amt);
    return (op == 0 || (op >= 4 && amt == 0)) ? 1 : op == 7 ? amt + 1 : 2;
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge of the following idle cycle.
  task automatic run(input int op, input int amt, input bit dir);
    logic [7:0] start = acc;
    logic [7:0] exp = ref_op(op, amt, dir, acc, load_data);
    int lat = 0;
    instr = {3'(op), 3'(amt), 1'($urandom), op == 7 ? dir : 1'($urandom)};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = 8'($urandom);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (n == 1) begin
        c_ctrl = acc_ctrl; c_ns = acc_num_shift; c_rs = acc_rs; c_setn = acc_set_n; c_clrn = acc_clr_n;
      end
      chk("ready_exec", instr_ready, 0);
      if (op == 7) begin
        chk("rot_step", acc, dir ? rotr(start, n - 1) : rotl(start, n - 1));
        chk("rot_ns", acc_num_shift, 1);
      end
    end
    chk("latency", lat, ref_lat(op, amt));
    chk("result", acc, exp);
    chk("done_ctrl", {instr_ready, busy, acc_clr_n, acc_set_n, acc_ctrl, acc_num_shift}, 9'b0_1_1_1_00_000);
    @(negedge clk);
    chk("idle_after", {instr_ready, busy, done}, 3'b100);
  endtask

  initial begin
    int d;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    model_on = 1'b1;
    @(negedge clk);
    chk("rst_flags", {instr_ready, busy, done}, 3'b100);
    chk("rst_ctrl", {acc_clr_n, acc_set_n, acc_ctrl, acc_num_shift, acc_ls, acc_rs}, 9'b11_00_000_00);

    load_data = 8'h81; run(3, 0, 0);
    run(7, 3, 0);
    chk("rotl3", acc, 8'h0C);
    load_data = 8'h81; run(3, 0, 0);
    run(7, 2, 1);
    chk("rotr2", acc, 8'h60);
    load_data = 8'h90; run(3, 0, 0);
    run(6, 3, 0);
    chk("asr_ctrl", {c_ctrl, c_ns, c_rs}, {2'b11, 3'd3, 1'b1});
    chk("asr_res", acc, 8'hF2);
    run(4, 0, 0);

    // Instruction held valid across a CLR: the second one is taken only once the sequencer is idle again.
    instr = 8'h20; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = 8'h40;
    @(negedge clk);
    chk("hs_exec", {busy, instr_ready, acc_clr_n}, 3'b100);
    @(negedge clk);
    chk("hs_done", {done, acc_set_n, acc}, {2'b11, 8'h00});
    @(negedge clk);
    chk("hs_idle", {instr_ready, busy}, 2'b10);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("hs_set", {busy, acc_set_n}, 2'b10);
    @(negedge clk);
    chk("hs_set_res", {done, acc}, {1'b1, 8'hFF});
    @(negedge clk);

    run(2, 0, 0);
    chk("b2b_set", c_setn, 0);
    load_data = 8'hA5; run(3, 0, 0);
    chk("b2b_load", {c_ctrl, c_setn, c_clrn}, 4'b0111);

    instr = {3'd7, 3'd5, 2'b00}; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    d = 0;
    @(negedge clk);
    d += int'(done);
    @(negedge clk);
    d += int'(done);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("abort_flags", {instr_ready, busy, done}, 3'b100);
    chk("abort_ctrl", {acc_clr_n, acc_set_n, acc_ctrl, acc_num_shift, acc_ls, acc_rs}, 9'b11_00_000_00);
    chk("abort_acc", acc, rotl(8'hA5, 2));
    for (int i = 0; i < 8; i++) begin
      d += int'(done);
      @(negedge clk);
    end
    chk("abort_nodone", d, 0);

    for (int i = 0; i < 80; i++) begin
      load_data = 8'($urandom);
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
